// File: rtl/siaminer_frame_codec_pkg.sv
// rtl/siaminer_frame_codec_pkg.sv - shared constants and state types for the UART frame codec
package siaminer_frame_codec_pkg;

  localparam logic [7:0] HDR_RX   = 8'hAA;
  localparam logic [7:0] HDR_TX   = 8'h55;
  localparam logic [7:0] CMD_WORK = 8'h00;
  localparam logic [7:0] CMD_LOOP = 8'h01;

  localparam int WORK_BYTES_DEF = 84;

  typedef enum logic [2:0] {R_HEAD, R_CMD, R_LEN, R_DATA, R_DROP} rx_state_e;
  typedef enum logic [2:0] {T_IDLE, T_HEAD, T_CMD, T_LEN, T_DATA} tx_state_e;

endpackage

// File: rtl/siaminer_frame_codec_if.sv
// rtl/siaminer_frame_codec_if.sv - UART byte streams, work load and nonce signals of the codec
interface siaminer_frame_codec_if
  import siaminer_frame_codec_pkg::*;
#(
  parameter int WORK_BYTES = WORK_BYTES_DEF
);
  logic [7:0]              rx_data;
  logic                    new_rx_data;
  logic [7:0]              tx_data;
  logic                    new_tx_data;
  logic                    tx_busy;
  logic [8*WORK_BYTES-1:0] work_data;
  logic                    work_valid;
  logic [31:0]             nonce;
  logic                    nonce_valid;
  logic                    frame_err;

  modport master (
    output rx_data, new_rx_data, tx_busy, nonce, nonce_valid,
    input  tx_data, new_tx_data, work_data, work_valid, frame_err
  );

  modport slave (
    input  rx_data, new_rx_data, tx_busy, nonce, nonce_valid,
    output tx_data, new_tx_data, work_data, work_valid, frame_err
  );
endinterface

// File: rtl/siaminer_frame_codec_frame_tx_seq.sv
// rtl/siaminer_frame_codec_frame_tx_seq.sv - response encoder: pending nonce/loop registers,
// transmit FSM and strobe pacing toward the UART transmitter.
module frame_tx_seq
  import siaminer_frame_codec_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] nonce,
  input  logic        nonce_valid,
  input  logic        loop_set,
  input  logic [7:0]  loop_byte,
  input  logic        tx_busy,
  output logic [7:0]  tx_data,
  output logic        new_tx_data
);
  tx_state_e   state_q, state_d;
  logic        nonce_pend_q, nonce_pend_d;
  logic        loop_pend_q, loop_pend_d;
  logic [31:0] nonce_hold_q, nonce_hold_d;
  logic [7:0]  loop_hold_q, loop_hold_d;
  logic [31:0] payload_q, payload_d;
  logic [7:0]  resp_cmd_q, resp_cmd_d;
  logic [1:0]  idx_q, idx_d;
  logic        strobe_q;
  logic        can_send, start_nonce, start_loop;
  logic [1:0]  last_idx;
  logic [31:0] shifted;

  always_comb begin
    state_d     = state_q;
    payload_d   = payload_q;
    resp_cmd_d  = resp_cmd_q;
    idx_d       = idx_q;
    new_tx_data = 1'b0;
    tx_data     = 8'h00;
    start_nonce = 1'b0;
    start_loop  = 1'b0;
    // The strobe of the previous cycle blocks this one so the UART sees tx_busy rise first.
    can_send    = !tx_busy && !strobe_q;
    last_idx    = (resp_cmd_q == CMD_WORK) ? 2'd3 : 2'd0;
    shifted     = payload_q >> {idx_q, 3'b000};

    unique case (state_q)
      T_IDLE: begin
        if (nonce_pend_q) begin
          start_nonce = 1'b1;
          payload_d   = nonce_hold_q;
          resp_cmd_d  = CMD_WORK;
          state_d     = T_HEAD;
        end else if (loop_pend_q) begin
          start_loop  = 1'b1;
          payload_d   = {24'h0, loop_hold_q};
          resp_cmd_d  = CMD_LOOP;
          state_d     = T_HEAD;
        end
      end
      T_HEAD: begin
        tx_data = HDR_TX;
        if (can_send) begin
          new_tx_data = 1'b1;
          state_d     = T_CMD;
        end
      end
      T_CMD: begin
        tx_data = resp_cmd_q;
        if (can_send) begin
          new_tx_data = 1'b1;
          state_d     = T_LEN;
        end
      end
      T_LEN: begin
        tx_data = (resp_cmd_q == CMD_WORK) ? 8'd4 : 8'd1;
        if (can_send) begin
          new_tx_data = 1'b1;
          idx_d       = 2'd0;
          state_d     = T_DATA;
        end
      end
      T_DATA: begin
        tx_data = shifted[7:0];
        if (can_send) begin
          new_tx_data = 1'b1;
          idx_d       = idx_q + 2'd1;
          if (idx_q == last_idx) state_d = T_IDLE;
        end
      end
      default: state_d = T_IDLE;
    endcase

    // A new event in the start cycle must survive as a follow-up response.
    nonce_pend_d = (nonce_pend_q && !start_nonce) || nonce_valid;
    nonce_hold_d = nonce_valid ? nonce : nonce_hold_q;
    loop_pend_d  = (loop_pend_q && !start_loop) || loop_set;
    loop_hold_d  = loop_set ? loop_byte : loop_hold_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= T_IDLE;
      nonce_pend_q <= 1'b0;
      loop_pend_q  <= 1'b0;
      nonce_hold_q <= '0;
      loop_hold_q  <= '0;
      payload_q    <= '0;
      resp_cmd_q   <= '0;
      idx_q        <= '0;
      strobe_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      nonce_pend_q <= nonce_pend_d;
      loop_pend_q  <= loop_pend_d;
      nonce_hold_q <= nonce_hold_d;
      loop_hold_q  <= loop_hold_d;
      payload_q    <= payload_d;
      resp_cmd_q   <= resp_cmd_d;
      idx_q        <= idx_d;
      strobe_q     <= new_tx_data;
    end
  end
endmodule

// File: rtl/siaminer_frame_codec.sv
// rtl/siaminer_frame_codec.sv - host frame decoder (work load / loop test) with the response
// encoder instantiated alongside; receive and transmit run independently.
module siaminer_frame_codec
  import siaminer_frame_codec_pkg::*;
#(
  parameter int WORK_BYTES     = WORK_BYTES_DEF,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input logic                   clk,
  input logic                   rst,
  siaminer_frame_codec_if.slave bus
);
  localparam int WW = 8 * WORK_BYTES;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  rx_state_e     state_q, state_d;
  logic [7:0]    cmd_q, cmd_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [WW-1:0] shadow_q, shadow_d;
  logic [WW-1:0] work_q, work_d;
  logic          work_valid_q, work_valid_d;
  logic          frame_err_q, frame_err_d;
  logic [TW-1:0] to_q, to_d;
  logic          timeout_hit;
  logic          loop_set;
  logic          legal;
  logic [7:0]    tx_data;
  logic          new_tx_data;

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    cnt_d        = cnt_q;
    shadow_d     = shadow_q;
    work_d       = work_q;
    work_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    loop_set     = 1'b0;
    legal        = ((cmd_q == CMD_WORK) && (bus.rx_data == 8'(WORK_BYTES))) ||
                   ((cmd_q == CMD_LOOP) && (bus.rx_data == 8'd1));

    if (state_q == R_HEAD || bus.new_rx_data) to_d = '0;
    else if (to_q != TW'(TIMEOUT_CYCLES))     to_d = to_q + TW'(1);
    else                                      to_d = to_q;
    timeout_hit = (state_q != R_HEAD) && !bus.new_rx_data && (to_q == TW'(TIMEOUT_CYCLES - 1));

    if (timeout_hit) begin
      state_d     = R_HEAD;
      frame_err_d = 1'b1;
      to_d        = '0;
    end else if (bus.new_rx_data) begin
      unique case (state_q)
        R_HEAD: if (bus.rx_data == HDR_RX) state_d = R_CMD;
        R_CMD: begin
          cmd_d   = bus.rx_data;
          state_d = R_LEN;
        end
        R_LEN: begin
          cnt_d = bus.rx_data;
          if (legal) begin
            state_d = R_DATA;
          end else begin
            frame_err_d = 1'b1;
            state_d     = (bus.rx_data == 8'd0) ? R_HEAD : R_DROP;
          end
        end
        R_DATA: begin
          cnt_d = cnt_q - 8'd1;
          if (cmd_q == CMD_LOOP) begin
            loop_set = 1'b1;
            state_d  = R_HEAD;
          end else begin
            // Shift right so the first payload byte ends at the bottom of the word.
            shadow_d = {bus.rx_data, shadow_q[WW-1:8]};
            if (cnt_q == 8'd1) begin
              work_d       = shadow_d;
              work_valid_d = 1'b1;
              state_d      = R_HEAD;
            end
          end
        end
        R_DROP: begin
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd1) state_d = R_HEAD;
        end
        default: state_d = R_HEAD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= R_HEAD;
      cmd_q        <= '0;
      cnt_q        <= '0;
      shadow_q     <= '0;
      work_q       <= '0;
      work_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      to_q         <= '0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      cnt_q        <= cnt_d;
      shadow_q     <= shadow_d;
      work_q       <= work_d;
      work_valid_q <= work_valid_d;
      frame_err_q  <= frame_err_d;
      to_q         <= to_d;
    end
  end

  frame_tx_seq u_tx (
    .clk         (clk),
    .rst         (rst),
    .nonce       (bus.nonce),
    .nonce_valid (bus.nonce_valid),
    .loop_set    (loop_set),
    .loop_byte   (bus.rx_data),
    .tx_busy     (bus.tx_busy),
    .tx_data     (tx_data),
    .new_tx_data (new_tx_data)
  );

  assign bus.tx_data     = tx_data;
  assign bus.new_tx_data = new_tx_data;
  assign bus.work_data   = work_q;
  assign bus.work_valid  = work_valid_q;
  assign bus.frame_err   = frame_err_q;
endmodule

// File: tb/tb_siaminer_frame_codec.sv
// tb/tb_siaminer_frame_codec.sv - frame-level reference model feeding a scoreboard; a negedge
// monitor checks every tx strobe, work load and frame error against it.
module tb_siaminer_frame_codec;
  import siaminer_frame_codec_pkg::*;

  localparam int WB = 84;
  localparam int TO = 300;
  localparam int WW = 8 * WB;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  siaminer_frame_codec_if #(.WORK_BYTES(WB)) bus ();

  siaminer_frame_codec #(.WORK_BYTES(WB), .TIMEOUT_CYCLES(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int            n_cmp = 0;
  int            n_fail = 0;
  int            cyc = 0;
  logic [8:0]    exp_tx[$];
  logic [WW-1:0] exp_work[$];
  int            exp_err = 0;
  logic [WW-1:0] last_work = '0;
  int            hdr_cyc = -1;
  int            rx_cyc = -1;
  int            nonce_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: got an event, want none", name);
  endtask

  // Monitor and UART transmitter model: busy for a random time after each strobe.
  initial begin
    int         busy_left;
    logic [8:0] e;
    logic       prev_strobe;
    busy_left   = 0;
    prev_strobe = 1'b0;
    bus.tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_strobe = 1'b0;
        busy_left   = 0;
      end else begin
        if (bus.new_tx_data) begin
          check("tx_pacing", {prev_strobe, bus.tx_busy}, '0);
          if (exp_tx.size() == 0) unexpected("tx_extra_byte");
          else begin
            e = exp_tx.pop_front();
            if (e[8]) hdr_cyc = cyc;
            check("tx_byte", bus.tx_data, e[7:0]);
          end
          busy_left = $urandom_range(0, 4);
        end
        if (bus.work_valid) begin
          if (exp_work.size() == 0) unexpected("work_extra");
          else check("work_data", bus.work_data, exp_work.pop_front());
        end
        if (bus.frame_err) begin
          if (exp_err == 0) unexpected("frame_err_extra");
          else begin
            exp_err--;
            n_cmp++;
          end
        end
        prev_strobe = bus.new_tx_data;
      end
      bus.tx_busy = (busy_left > 0);
      if (busy_left > 0) busy_left--;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bus.rx_data     = b;
    bus.new_rx_data = 1'b1;
    rx_cyc          = cyc;
    step();
    bus.new_rx_data = 1'b0;
    repeat (gap) step();
  endtask

  task automatic push_nonce(input logic [31:0] n);
    exp_tx.push_back({1'b1, 8'h55});
    exp_tx.push_back({1'b0, 8'h00});
    exp_tx.push_back({1'b0, 8'h04});
    for (int i = 0; i < 4; i++) exp_tx.push_back({1'b0, n[8*i +: 8]});
  endtask

  task automatic push_loop(input logic [7:0] b);
    exp_tx.push_back({1'b1, 8'h55});
    exp_tx.push_back({1'b0, 8'h01});
    exp_tx.push_back({1'b0, 8'h01});
    exp_tx.push_back({1'b0, b});
  endtask

  // Frame-level model: legal work -> load, legal loop -> echo, anything else -> one error.
  task automatic send_frame(input logic [7:0] cmd, input logic [7:0] len,
                            input logic [7:0] pl[$], input int gmax);
    logic [WW-1:0] w;
    if (cmd == 8'h00 && len == 8'(WB)) begin
      w = '0;
      for (int i = 0; i < WB; i++) w[8*i +: 8] = pl[i];
      exp_work.push_back(w);
      last_work = w;
    end else if (cmd == 8'h01 && len == 8'd1) begin
      push_loop(pl[0]);
    end else begin
      exp_err++;
    end
    send_byte(8'hAA, $urandom_range(0, gmax));
    send_byte(cmd, $urandom_range(0, gmax));
    send_byte(len, $urandom_range(0, gmax));
    for (int i = 0; i < pl.size(); i++) send_byte(pl[i], $urandom_range(0, gmax));
  endtask

  task automatic issue_nonce(input logic [31:0] n);
    push_nonce(n);
    bus.nonce       = n;
    bus.nonce_valid = 1'b1;
    nonce_cyc       = cyc;
    step();
    bus.nonce_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_tx.size() != 0 || exp_work.size() != 0 || exp_err != 0) && t < 3000) begin
      step();
      t++;
    end
    n_cmp++;
    if (t >= 3000) begin
      n_fail++;
      $display("FAIL drain_timeout: pending tx=%0d work=%0d err=%0d, want all 0",
               exp_tx.size(), exp_work.size(), exp_err);
      exp_tx.delete();
      exp_work.delete();
      exp_err = 0;
    end
    repeat (8) step();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_work_data"}, bus.work_data, '0);
    check({tag, "_work_valid"}, bus.work_valid, '0);
    check({tag, "_frame_err"}, bus.frame_err, '0);
    check({tag, "_new_tx_data"}, bus.new_tx_data, '0);
    check({tag, "_tx_data"}, bus.tx_data, '0);
  endtask

  task automatic rand_payload(input int n, output logic [7:0] pl[$]);
    pl.delete();
    for (int i = 0; i < n; i++) pl.push_back(8'($urandom_range(0, 255)));
  endtask

  initial begin
    logic [7:0] pl[$];
    logic [7:0] b;
    int         kind;

    rst             = 1'b1;
    bus.rx_data     = '0;
    bus.new_rx_data = 1'b0;
    bus.nonce       = '0;
    bus.nonce_valid = 1'b0;
    repeat (3) step();
    check_outputs_zero("reset");
    rst = 1'b0;
    step();

    pl = {8'h5A};
    send_frame(8'h01, 8'h01, pl, 0);
    wait_drain();
    check("loop_latency", 32'(hdr_cyc - rx_cyc), 2);

    pl.delete();
    for (int i = 0; i < WB; i++) pl.push_back(8'(i));
    send_frame(8'h00, 8'(WB), pl, 1);
    wait_drain();

    issue_nonce(32'h12345678);
    wait_drain();
    check("nonce_latency", 32'(hdr_cyc - nonce_cyc), 2);

    pl = {8'hAA, 8'h01, 8'h01};
    send_frame(8'h02, 8'h03, pl, 1);
    pl = {8'h33};
    send_frame(8'h01, 8'h01, pl, 1);
    wait_drain();

    // Longest gap that must not abort, then a stall that must.
    rand_payload(WB, pl);
    send_frame(8'h00, 8'(WB), pl, 0);
    wait_drain();
    send_byte(8'hAA, 0);
    send_byte(8'h00, 0);
    send_byte(8'(WB), 0);
    for (int i = 0; i < 10; i++) send_byte(8'($urandom_range(0, 255)), (i == 4) ? TO - 1 : 0);
    exp_err++;
    repeat (TO + 10) step();
    wait_drain();
    check("timeout_work_kept", bus.work_data, last_work);
    rand_payload(WB, pl);
    send_frame(8'h00, 8'(WB), pl, 2);
    wait_drain();

    send_byte(8'hAA, 0);
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    push_nonce(32'hCAFEF00D);
    push_loop(8'h77);
    bus.rx_data     = 8'h77;
    bus.new_rx_data = 1'b1;
    bus.nonce       = 32'hCAFEF00D;
    bus.nonce_valid = 1'b1;
    step();
    bus.new_rx_data = 1'b0;
    bus.nonce_valid = 1'b0;
    wait_drain();

    for (int it = 0; it < 30; it++) begin
      repeat ($urandom_range(0, 3)) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'hAA) b = 8'h00;
        send_byte(b, $urandom_range(0, 2));
      end
      kind = $urandom_range(0, 3);
      case (kind)
        0: begin
          rand_payload(WB, pl);
          send_frame(8'h00, 8'(WB), pl, 2);
        end
        1: begin
          rand_payload(1, pl);
          send_frame(8'h01, 8'h01, pl, 3);
        end
        2: begin
          rand_payload($urandom_range(0, 6), pl);
          send_frame(8'($urandom_range(0, 5)), 8'(pl.size()), pl, 3);
        end
        default: issue_nonce($urandom);
      endcase
      wait_drain();
    end

    rand_payload(WB, pl);
    send_byte(8'hAA, 0);
    send_byte(8'h00, 0);
    send_byte(8'(WB), 0);
    for (int i = 0; i < 20; i++) send_byte(pl[i], 0);
    rst = 1'b1;
    step();
    check_outputs_zero("midreset");
    step();
    rst       = 1'b0;
    last_work = '0;
    step();
    pl = {8'hC3};
    send_frame(8'h01, 8'h01, pl, 1);
    rand_payload(WB, pl);
    send_frame(8'h00, 8'(WB), pl, 1);
    wait_drain();

    check("end_tx_queue", 32'(exp_tx.size()), 0);
    check("end_work_queue", 32'(exp_work.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/siaminer_frame_codec.md
# siaminer_frame_codec

Byte-level framing codec between the UART transceiver and the Sia mining core, inside the UART-to-core bridge. Decodes host frames `0xAA, cmd, len, payload` from the UART receive byte stream into a 672-bit work load or a loop-test byte. Encodes device responses `0x55, cmd, len, payload` (found nonce, loop echo) into the UART transmit byte stream.

## Interface
Parameters:
- `WORK_BYTES`, 84: payload length of a work frame. Payload is 640-bit header work plus 32-bit target.
- `TIMEOUT_CYCLES`, 50000: idle cycles allowed between bytes inside a frame before the frame is aborted.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: synchronous, active-high reset.
- `rx_data`, in, 8: received byte, valid with `new_rx_data`.
- `new_rx_data`, in, 1: one-cycle strobe, new received byte.
- `tx_data`, out, 8: byte to transmit, valid with `new_tx_data`.
- `new_tx_data`, out, 1: one-cycle strobe, start transmit of `tx_data`.
- `tx_busy`, in, 1: UART transmitter busy.
- `work_data`, out, 672: last complete work payload. Byte k of the payload is at bits [8k+7:8k]. Work is bits [639:0]; target is bits [671:640].
- `work_valid`, out, 1: one-cycle strobe, `work_data` updated.
- `nonce`, in, 32: found nonce from the core.
- `nonce_valid`, in, 1: one-cycle strobe, `nonce` valid.
- `frame_err`, out, 1: one-cycle strobe on a dropped or aborted frame.

## Operation
Receive FSM, states R_HEAD, R_CMD, R_LEN, R_DATA, R_DROP:
- R_HEAD: on a byte equal to 0xAA, go to R_CMD. Any other byte is ignored silently.
- R_CMD: store `cmd`, go to R_LEN.
- R_LEN: store `len` and load the byte counter with `len`.
  - Legal frames are cmd 0 with len = WORK_BYTES, and cmd 1 with len = 1. A legal frame goes to R_DATA.
  - Any other cmd/len pair pulses `frame_err` and goes to R_DROP. If len = 0 in that case, go straight to R_HEAD.
- R_DATA, cmd 0: shift each byte into a 672-bit shadow register, first byte ending at [7:0].
  - On the last byte, copy the shadow to `work_data`, pulse `work_valid`, and return to R_HEAD.
- R_DATA, cmd 1: latch the byte into the loop-pending register, set `loop_pend`, and return to R_HEAD.
- R_DROP: consume the counted bytes and discard them, then return to R_HEAD.
- Timeout: in any state other than R_HEAD, TIMEOUT_CYCLES consecutive cycles without `new_rx_data` abort the frame.
  - On abort: go to R_HEAD, pulse `frame_err`, leave `work_data` unchanged.

Transmit FSM, states T_IDLE, T_HEAD, T_CMD, T_LEN, T_DATA:
- Nonce holding register: `nonce_valid` latches `nonce` and sets `nonce_pend`.
  - A new `nonce_valid` while a nonce response is in flight sets pending again for a follow-up response.
  - A new `nonce_valid` while pending but not started overwrites the held nonce.
- T_IDLE: if `nonce_pend`, start a nonce response (priority). Otherwise, if `loop_pend`, start a loop response.
  - Starting clears the corresponding pending flag and snapshots the payload.
- Nonce response bytes: 0x55, 0x00, 0x04, then nonce[7:0], [15:8], [23:16], [31:24].
- Loop response bytes: 0x55, 0x01, 0x01, then the echoed byte.
- A new loop byte arriving while `loop_pend` is set overwrites it. Only the latest byte is echoed.

## Timing
- Reset values:
  - All outputs 0.
  - `work_data` = 0.
  - Receive FSM in R_HEAD, transmit FSM in T_IDLE.
  - Pending flags, counters and timeout counter cleared.
- Reset mid-frame discards the partial frame and any pending response.
- `work_valid` is asserted in the cycle after the `new_rx_data` cycle of the last payload byte. `work_data` is valid in that same cycle.
- Transmit handshake:
  - `new_tx_data` pulses only in a cycle where `tx_busy` = 0 and the previous cycle had no pulse, giving at least two cycles between strobes.
  - `tx_data` holds its value in the strobe cycle.
- First header byte: earliest `new_tx_data` is two cycles after `nonce_valid`, or two cycles after the loop byte's `new_rx_data`.
- Simultaneous events:
  - `nonce_valid` and a loop-byte completion in the same cycle both become pending; the nonce is sent first.
  - Receive and transmit proceed fully in parallel.
- Timeout counter:
  - Saturates; it never wraps.
  - Reloads on every `new_rx_data`.
  - Abort fires in the cycle the count reaches TIMEOUT_CYCLES.

## Structure
- Shared package holds:
  - Constants HDR_RX = 0xAA, HDR_TX = 0x55, CMD_WORK = 0x00, CMD_LOOP = 0x01.
  - WORK_BYTES default.
  - Receive and transmit state enums.
- One natural sub-module, `frame_tx_seq`: the transmit FSM, pending registers and handshake pacing. The receive FSM stays in the top level.

## Test plan
- Loop frame AA 01 01 5A -> response 55 01 01 5A. No `work_valid`, no `frame_err`.
- Work frame AA 00 54 with payload bytes 00..53 -> one `work_valid`; `work_data`[7:0] = 0x00, [671:664] = 0x53.
- `nonce_valid` with nonce = 0x12345678 -> response 55 00 04 78 56 34 12. Each strobe occurs only while `tx_busy` = 0, with at least two cycles between strobes.
- Bad frames:
  - AA 02 03 x x x -> one `frame_err`; all 3 bytes dropped.
  - A following AA 01 01 33 -> echo 33.
- Work frame stalled after 10 payload bytes for TIMEOUT_CYCLES -> `frame_err`, `work_data` unchanged. A following full work frame succeeds.
- `nonce_valid` in the same cycle as a loop-byte completion -> nonce response sent fully before the loop response. Assert `rst` mid-work-frame -> all outputs 0; the next frame decodes normally.
